i2s_frame_scheduler: RTL and testbench

- Master-mode frame controller for the DAC serializer.
- Derives BCLK and DACLRCK from the system clock and accepts stereo sample pairs from the effects chain over a valid/ready handshake.
- Presents leftSample/rightSample to the serializer, held stable for a full frame and updated only at frame boundaries.
- Detects and counts underruns when upstream fails to supply a pair in time.

---
 rtl/audio_pkg.sv | 18 +
 rtl/bclk_gen.sv | 65 ++++++
 rtl/i2s_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_i2s_frame_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and default sizing for the I2S frame scheduler.
// Pulled in by both the top level and the bit-clock generator.
package audio_pkg;

    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_SLOT_BITS = 16;
    localparam int DEF_BCLK_HALF = 16;
    localparam int DEF_UCNT_W    = 8;

    typedef logic [DEF_SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } sched_state_t;

endpackage

// File: rtl/bclk_gen.sv
// bclk_gen: divides the system clock into BCLK and DACLRCK and flags
// the cycle that opens each frame.
module bclk_gen
    import audio_pkg::*;
#(
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int BCLK_HALF = DEF_BCLK_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic halt,
    output logic bclk,
    output logic lrck,
    output logic frame_start
);

    localparam int DW = $clog2(BCLK_HALF);
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [DW-1:0] DIV_LAST    = DW'(BCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] RIGHT_FIRST = BW'(SLOT_BITS);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;
    logic          div_wrap;
    logic          fall;
    logic          wrap;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign fall     = div_wrap && bclk;
    assign wrap     = fall && (bit_cnt == BIT_LAST);
    assign bit_nxt  = wrap ? '0 : bit_cnt + 1'b1;

    // Word select follows the new bit index so it moves with BCLK's fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            frame_start <= 1'b0;
        end else if (!run || halt) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            frame_start <= start;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk <= !bclk;
            end
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= (bit_nxt >= RIGHT_FIRST);
            end
            frame_start <= wrap;
        end
    end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler: I2S master frame controller with a one-pair buffer.
// Define UNDERRUN_MUTE_EN to output silence on frames that underrun.
module i2s_frame_scheduler
    import audio_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int BCLK_HALF = DEF_BCLK_HALF,
    parameter int UCNT_W    = DEF_UCNT_W
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                BCLK,
    output logic                DACLRCK,
    output logic [SAMPLE_W-1:0] leftSample,
    output logic [SAMPLE_W-1:0] rightSample,
    output logic                frame_start,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_cnt
);

    sched_state_t state;
    sched_state_t state_nxt;

    logic [SAMPLE_W-1:0] pend_l;
    logic [SAMPLE_W-1:0] pend_r;
    logic                pend_full;
    logic                pf_nxt;
    logic                stop_q;
    logic                accept;
    logic                bnd;
    logic                start;
    logic                halt;
    logic                xfer;
    logic                miss;

    assign accept = in_valid && in_ready;
    assign bnd    = frame_start && (state == RUN);

    bclk_gen #(
        .SLOT_BITS(SLOT_BITS),
        .BCLK_HALF(BCLK_HALF)
    ) u_bclk_gen (
        .clk        (CLOCK_50),
        .rst        (reset),
        .start      (start),
        .run        (state == RUN),
        .halt       (halt),
        .bclk       (BCLK),
        .lrck       (DACLRCK),
        .frame_start(frame_start)
    );

    // A stop request is honoured only at a frame boundary
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        halt      = 1'b0;
        xfer      = 1'b0;
        miss      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (pend_full) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (bnd) begin
                    if (stop_q || !enable) begin
                        state_nxt = IDLE;
                        halt      = 1'b1;
                    end else if (pend_full) begin
                        xfer = 1'b1;
                    end else begin
                        miss = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pf_nxt = pend_full;
        if (xfer) begin
            pf_nxt = 1'b0;
        end
        if (accept) begin
            pf_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            stop_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != RUN) begin
                stop_q <= 1'b0;
            end else if (!enable) begin
                stop_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pend_l       <= '0;
            pend_r       <= '0;
            pend_full    <= 1'b0;
            in_ready     <= 1'b0;
            leftSample   <= '0;
            rightSample  <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            pend_full <= pf_nxt;
            in_ready  <= !pf_nxt;
            underrun  <= miss;
            if (accept) begin
                pend_l <= in_left;
                pend_r <= in_right;
            end
            if (xfer) begin
                leftSample  <= pend_l;
                rightSample <= pend_r;
            end
`ifdef UNDERRUN_MUTE_EN
            else if (miss) begin
                leftSample  <= '0;
                rightSample <= '0;
            end
`endif
            if (miss && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// tb_i2s_frame_scheduler: random and directed stimulus against a
// frame-arithmetic reference model of the scheduler.
`timescale 1ns/1ps
module tb_i2s_frame_scheduler;

    localparam int SW    = 16;
    localparam int SB    = 4;
    localparam int BH    = 2;
    localparam int UW    = 8;
    localparam int FRAME = 4 * SB * BH;
    localparam int UMAX  = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          v   = 1'b0;
    logic [SW-1:0] il  = '0;
    logic [SW-1:0] ir  = '0;
    logic          in_ready;
    logic          bclk;
    logic          lrck;
    logic [SW-1:0] lsamp;
    logic [SW-1:0] rsamp;
    logic          fstart;
    logic          urun;
    logic [UW-1:0] ucnt;

    always #10 clk = ~clk;

    i2s_frame_scheduler #(
        .SAMPLE_W (SW),
        .SLOT_BITS(SB),
        .BCLK_HALF(BH),
        .UCNT_W   (UW)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .enable      (en),
        .in_valid    (v),
        .in_ready    (in_ready),
        .in_left     (il),
        .in_right    (ir),
        .BCLK        (bclk),
        .DACLRCK     (lrck),
        .leftSample  (lsamp),
        .rightSample (rsamp),
        .frame_start (fstart),
        .underrun    (urun),
        .underrun_cnt(ucnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 waiting for first pair, 2 running
    int              m_mode;
    int              m_t;
    bit              m_stop;
    bit              m_rdy;
    bit              m_ur;
    bit              m_acc;
    int              m_ucnt;
    logic [SW-1:0]   m_l;
    logic [SW-1:0]   m_r;
    logic [2*SW-1:0] pq[$];
    logic [2*SW-1:0] oq[$];
    bit              withhold = 1'b0;
    int              p_valid  = 100;

    function automatic void model_reset();
        m_mode = 0;
        m_t    = 0;
        m_stop = 0;
        m_rdy  = 0;
        m_ur   = 0;
        m_acc  = 0;
        m_ucnt = 0;
        m_l    = '0;
        m_r    = '0;
        pq.delete();
    endfunction

    function automatic void model_edge();
        m_acc = v && m_rdy;
        m_ur  = 0;
        case (m_mode)
            0: if (en) m_mode = 1;
            1: begin
                if (!en) m_mode = 0;
                else if (pq.size() != 0) begin
                    m_mode = 2;
                    m_t    = 0;
                end
            end
            default: begin
                if (m_t % FRAME == 0) begin
                    if (m_stop || !en) m_mode = 0;
                    else if (pq.size() != 0) {m_l, m_r} = pq.pop_front();
                    else begin
                        m_ur = 1;
                        if (m_ucnt < UMAX) m_ucnt++;
`ifdef UNDERRUN_MUTE_EN
                        m_l = '0;
                        m_r = '0;
`endif
                    end
                end
                if (m_mode == 2) begin
                    if (!en) m_stop = 1;
                    m_t++;
                end else begin
                    m_stop = 0;
                end
            end
        endcase
        if (m_acc) pq.push_back({il, ir});
        m_rdy = (pq.size() == 0);
    endfunction

    task automatic check_all();
        bit run;
        run = (m_mode == 2);
        check("frame_start", fstart, run && (m_t % FRAME == 0));
        check("bclk", bclk, run ? (m_t / BH) % 2 : 0);
        check("daclrck", lrck, run ? ((m_t % FRAME) >= FRAME / 2) : 0);
        check("in_ready", in_ready, m_rdy);
        check("left", lsamp, m_l);
        check("right", rsamp, m_r);
        check("underrun", urun, m_ur);
        check("ucnt", ucnt, m_ucnt);
    endtask

    // Called at a falling edge: drive, predict, then check after next rise
    task automatic tick();
        v  = 1'b0;
        il = SW'($urandom);
        ir = SW'($urandom);
        if (!withhold && oq.size() != 0 && $urandom_range(99) < p_valid) begin
            v        = 1'b1;
            {il, ir} = oq[0];
        end
        model_edge();
        if (m_acc) void'(oq.pop_front());
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_pos(input int pos, input int limit);
        bit hit;
        hit = 0;
        for (int i = 0; i < limit && !hit; i++) begin
            if (m_mode == 2 && (m_t % FRAME) == pos) hit = 1;
            else tick();
        end
        if (!hit) check("wait_pos_timeout", 0, 1);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        check("rst_bclk", bclk, 0);
        check("rst_lrck", lrck, 0);
        check("rst_ready", in_ready, 0);
        check("rst_left", lsamp, 0);
        check("rst_right", rsamp, 0);
        check("rst_fstart", fstart, 0);
        check("rst_urun", urun, 0);
        check("rst_ucnt", ucnt, 0);
        model_reset();
        oq.delete();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        tick();
        check("ready_after_rst", in_ready, 1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clk);
        async_reset();

        en = 1'b1;
        oq.push_back({16'h1234, 16'hABCD});
        wait_pos(0, 20);
        tick();
        check("first_left", lsamp, 16'h1234);
        check("first_right", rsamp, 16'hABCD);

        wait_pos(5, 2 * FRAME);
        oq.push_back({16'h0001, 16'hFFFF});
        tick();
        check("ready_low_held", in_ready, 0);
        wait_pos(0, 2 * FRAME);
        check("left_before_bnd", lsamp, 16'h1234);
        tick();
        check("left_after_bnd", lsamp, 16'h0001);
        check("right_after_bnd", rsamp, 16'hFFFF);
        check("ready_after_bnd", in_ready, 1);

        withhold = 1'b1;
        repeat (3 * FRAME) tick();
        check("ucnt_three", ucnt, 3);
`ifdef UNDERRUN_MUTE_EN
        check("left_starved", lsamp, 0);
`else
        check("left_starved", lsamp, 16'h0001);
        check("right_starved", rsamp, 16'hFFFF);
`endif
        repeat (252 * FRAME) tick();
        check("ucnt_255", ucnt, UMAX);
        repeat (FRAME) tick();
        check("ucnt_sat", ucnt, UMAX);

        wait_pos(FRAME / 2 + 3, 2 * FRAME);
        async_reset();

        withhold = 1'b0;
        for (int seg = 0; seg < 20; seg++) begin
            case ($urandom_range(2))
                0: p_valid = 100;
                1: p_valid = 30;
                default: p_valid = 1;
            endcase
            for (int c = 0; c < 200; c++) begin
                if (oq.size() == 0)
                    oq.push_back({SW'($urandom), SW'($urandom)});
                if (en && $urandom_range(299) == 0) en = 1'b0;
                else if (!en && $urandom_range(19) == 0) en = 1'b1;
                tick();
            end
        end

        en      = 1'b1;
        p_valid = 100;
        for (int k = 0; k < 4; k++) oq.push_back({SW'($urandom), SW'($urandom)});
        wait_pos(9, 4 * FRAME);
        en = 1'b0;
        for (int i = 0; i < 2 * FRAME && m_mode == 2; i++) tick();
        check("stopped_idle", m_mode, 0);
        tick();
        check("stop_bclk", bclk, 0);
        check("stop_lrck", lrck, 0);
        check("stop_urun", urun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
